// File: rtl/op_decode_pipe.sv
// op_decode_pipe: decodes a raw instruction word into datapath control
// fields and buffers the result in a two-entry skid buffer (output register
// plus skid register). The ready signal toward the producer is registered,
// so there is no combinational path from out_ready back to in_ready.
module op_decode_pipe #(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 8,
    localparam int OP_W  = DATA_W + 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_code,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        src,
    output logic [2:0]        dst,
    output logic [DATA_W-1:0] const_val,
    output logic [3:0]        pc_instr,
    output logic [1:0]        alu_instr,
    output logic [1:0]        registers_instr,
    output logic [1:0]        in_mux_sel,
    output logic              out_mux_sel,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_SWP = 4'd2;
    localparam logic [3:0] OP_SAV = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JEZ = 4'd8;
    localparam logic [3:0] OP_JNZ = 4'd9;
    localparam logic [3:0] OP_JGZ = 4'd10;
    localparam logic [3:0] OP_JLZ = 4'd11;
    localparam logic [3:0] OP_JRO = 4'd12;

    // Operand locations
    localparam logic [2:0] LOC_ACC = 3'd0;
    localparam logic [2:0] LOC_NIL = 3'd1;
    localparam logic [2:0] LOC_IMM = 3'd7;

    // Control encodings
    localparam logic [3:0] PC_INC = 4'd0;
    localparam logic [3:0] PC_JMP = 4'd1;
    localparam logic [3:0] PC_JEZ = 4'd2;
    localparam logic [3:0] PC_JNZ = 4'd3;
    localparam logic [3:0] PC_JGZ = 4'd4;
    localparam logic [3:0] PC_JLZ = 4'd5;
    localparam logic [3:0] PC_JRO = 4'd6;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;
    localparam logic [1:0] ALU_NEG  = 2'd3;

    localparam logic [1:0] REG_NONE      = 2'd0;
    localparam logic [1:0] REG_WRITE_ACC = 2'd1;
    localparam logic [1:0] REG_SWP       = 2'd2;
    localparam logic [1:0] REG_SAV       = 2'd3;

    localparam logic [1:0] IN_ACC   = 2'd0;
    localparam logic [1:0] IN_CONST = 2'd1;
    localparam logic [1:0] IN_PORT  = 2'd2;
    localparam logic [1:0] IN_ZERO  = 2'd3;

    typedef struct packed {
        logic [2:0]        src;
        logic [2:0]        dst;
        logic [DATA_W-1:0] cval;
        logic [3:0]        pc;
        logic [1:0]        alu;
        logic [1:0]        regs;
        logic [1:0]        in_sel;
        logic              out_sel;
        logic              illegal;
    } entry_t;

    // Maps an operand location onto the ALU input mux selection
    function automatic logic [1:0] src_sel(input logic [2:0] loc);
        logic [1:0] sel;
        if (loc == LOC_ACC) begin
            sel = IN_ACC;
        end else if (loc == LOC_IMM) begin
            sel = IN_CONST;
        end else if (loc == LOC_NIL) begin
            sel = IN_ZERO;
        end else begin
            sel = IN_PORT;
        end
        return sel;
    endfunction

    logic [3:0]        f_op;
    logic [2:0]        f_src;
    logic [2:0]        f_dst;
    logic [DATA_W-1:0] f_imm;
    entry_t            dec;

    assign f_op  = op_code[OP_W-1 -: 4];
    assign f_src = op_code[OP_W-5 -: 3];
    assign f_imm = op_code[DATA_W+2:3];
    assign f_dst = op_code[2:0];

    // Decode the incoming word; illegal words keep NOP controls
    always_comb begin
        dec         = '0;
        dec.src     = f_src;
        dec.dst     = f_dst;
        dec.cval    = f_imm;
        dec.pc      = PC_INC;
        dec.alu     = ALU_PASS;
        dec.regs    = REG_NONE;
        dec.in_sel  = IN_ZERO;
        dec.out_sel = 1'b0;
        dec.illegal = 1'b0;
        case (f_op)
            OP_NOP: begin
                dec.in_sel = IN_ZERO;
            end
            OP_MOV: begin
                if (f_dst == LOC_IMM) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.in_sel = src_sel(f_src);
                    if (f_dst == LOC_ACC) begin
                        dec.regs = REG_WRITE_ACC;
                    end else if (f_dst != LOC_NIL) begin
                        dec.out_sel = 1'b1;
                    end
                end
            end
            OP_SWP: begin
                dec.regs   = REG_SWP;
                dec.in_sel = IN_ACC;
            end
            OP_SAV: begin
                dec.regs   = REG_SAV;
                dec.in_sel = IN_ACC;
            end
            OP_ADD: begin
                dec.alu    = ALU_ADD;
                dec.regs   = REG_WRITE_ACC;
                dec.in_sel = src_sel(f_src);
            end
            OP_SUB: begin
                dec.alu    = ALU_SUB;
                dec.regs   = REG_WRITE_ACC;
                dec.in_sel = src_sel(f_src);
            end
            OP_NEG: begin
                dec.alu    = ALU_NEG;
                dec.regs   = REG_WRITE_ACC;
                dec.in_sel = IN_ACC;
            end
            OP_JMP: begin
                dec.pc     = PC_JMP;
                dec.in_sel = IN_CONST;
            end
            OP_JEZ: begin
                dec.pc     = PC_JEZ;
                dec.in_sel = IN_CONST;
            end
            OP_JNZ: begin
                dec.pc     = PC_JNZ;
                dec.in_sel = IN_CONST;
            end
            OP_JGZ: begin
                dec.pc     = PC_JGZ;
                dec.in_sel = IN_CONST;
            end
            OP_JLZ: begin
                dec.pc     = PC_JLZ;
                dec.in_sel = IN_CONST;
            end
            OP_JRO: begin
                dec.pc     = PC_JRO;
                dec.in_sel = src_sel(f_src);
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    entry_t           out_entry_q, out_entry_d;
    entry_t           skid_entry_q, skid_entry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Skid buffer next state: output slot refills from skid first, flush empties both
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_entry_d  = out_entry_q;
        skid_entry_d = skid_entry_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_entry_d  = skid_entry_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_entry_d = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_entry_d = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    // Saturating count of illegal words taken in (flushed offers are not taken)
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !flush && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with synchronous reset overriding flush and handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_entry_q  <= '0;
            skid_entry_q <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            out_entry_q  <= out_entry_d;
            skid_entry_q <= skid_entry_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign src             = out_entry_q.src;
    assign dst             = out_entry_q.dst;
    assign const_val       = out_entry_q.cval;
    assign pc_instr        = out_entry_q.pc;
    assign alu_instr       = out_entry_q.alu;
    assign registers_instr = out_entry_q.regs;
    assign in_mux_sel      = out_entry_q.in_sel;
    assign out_mux_sel     = out_entry_q.out_sel;
    assign illegal         = out_entry_q.illegal;
    assign illegal_count   = cnt_q;

endmodule

// File: tb/tb_op_decode_pipe.sv
// tb_op_decode_pipe: directed decode table, hand-written buffering corner
// cases and a randomized run against a queue-based reference model.
module tb_op_decode_pipe;

    localparam int DW = 11;

    typedef struct packed {
        logic [2:0]    src;
        logic [2:0]    dst;
        logic [DW-1:0] cval;
        logic [3:0]    pc;
        logic [1:0]    alu;
        logic [1:0]    rg;
        logic [1:0]    insel;
        logic          outsel;
        logic          ill;
    } ent_t;

    typedef struct {
        logic [20:0]   opc;
        logic [3:0]    pc;
        logic [1:0]    alu;
        logic [1:0]    rg;
        logic [1:0]    insel;
        logic          outsel;
        logic          ill;
        logic [DW-1:0] cval;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset, in_valid, flush, out_ready;
    logic [20:0]   op_code;
    logic          in_ready, out_valid, out_mux_sel, illegal;
    logic [2:0]    src, dst;
    logic [DW-1:0] const_val;
    logic [3:0]    pc_instr;
    logic [1:0]    alu_instr, registers_instr, in_mux_sel;
    logic [7:0]    illegal_count;

    logic          in_ready2, out_valid2, out_mux_sel2, illegal2;
    logic [2:0]    src2, dst2;
    logic [DW-1:0] const_val2;
    logic [3:0]    pc_instr2;
    logic [1:0]    alu_instr2, registers_instr2, in_mux_sel2;
    logic [1:0]    illegal_count2;

    int   total = 0;
    int   bad = 0;
    ent_t q[$];
    int   ill_cnt = 0;
    vec_t vecs[16];

    op_decode_pipe #(.DATA_W(DW), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .src(src), .dst(dst), .const_val(const_val), .pc_instr(pc_instr),
        .alu_instr(alu_instr), .registers_instr(registers_instr), .in_mux_sel(in_mux_sel),
        .out_mux_sel(out_mux_sel), .illegal(illegal), .illegal_count(illegal_count)
    );

    op_decode_pipe #(.DATA_W(DW), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .op_code(op_code), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .src(src2), .dst(dst2), .const_val(const_val2), .pc_instr(pc_instr2),
        .alu_instr(alu_instr2), .registers_instr(registers_instr2), .in_mux_sel(in_mux_sel2),
        .out_mux_sel(out_mux_sel2), .illegal(illegal2), .illegal_count(illegal_count2)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [20:0] mk(input int op, input int s, input int imm, input int d);
        logic [3:0]    o;
        logic [2:0]    sv;
        logic [DW-1:0] iv;
        logic [2:0]    dv;
        o  = op[3:0];
        sv = s[2:0];
        iv = imm[DW-1:0];
        dv = d[2:0];
        return {o, sv, iv, dv};
    endfunction

    function automatic logic [1:0] ref_sel(input int s);
        if (s == 0) return 2'd0;
        if (s == 7) return 2'd1;
        if (s == 1) return 2'd3;
        return 2'd2;
    endfunction

    function automatic ent_t ref_decode(input logic [20:0] w);
        ent_t r;
        int   op, s, d;
        op = int'(w[20:17]);
        s  = int'(w[16:14]);
        d  = int'(w[2:0]);
        r = '0;
        r.src   = w[16:14];
        r.dst   = w[2:0];
        r.cval  = w[13:3];
        r.insel = 2'd3;
        if (op >= 13) begin
            r.ill = 1'b1;
        end else if (op == 1) begin
            if (d == 7) begin
                r.ill = 1'b1;
            end else begin
                r.insel  = ref_sel(s);
                r.rg     = (d == 0) ? 2'd1 : 2'd0;
                r.outsel = (d >= 2);
            end
        end else if (op == 2 || op == 3) begin
            r.rg    = 2'(op);
            r.insel = 2'd0;
        end else if (op == 4 || op == 5) begin
            r.alu   = 2'(op - 3);
            r.rg    = 2'd1;
            r.insel = ref_sel(s);
        end else if (op == 6) begin
            r.alu   = 2'd3;
            r.rg    = 2'd1;
            r.insel = 2'd0;
        end else if (op >= 7 && op <= 11) begin
            r.pc    = 4'(op - 6);
            r.insel = 2'd1;
        end else if (op == 12) begin
            r.pc    = 4'd6;
            r.insel = ref_sel(s);
        end
        return r;
    endfunction

    function automatic ent_t dut_entry();
        ent_t a;
        a = {src, dst, const_val, pc_instr, alu_instr, registers_instr, in_mux_sel, out_mux_sel, illegal};
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compares every observable against the reference model state
    task automatic checkOutput();
        int c8, c2;
        c8 = (ill_cnt > 255) ? 255 : ill_cnt;
        c2 = (ill_cnt > 3) ? 3 : ill_cnt;
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("illegal_count", 32'(illegal_count), 32'(c8));
        check("illegal_count_cnt2", 32'(illegal_count2), 32'(c2));
        check("out_valid_cnt2", 32'(out_valid2), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("entry", 32'(dut_entry()), 32'(q[0]));
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge, then checks
    task automatic applyStimulus(input logic v, input logic [20:0] opc, input logic rdy,
                                 input logic fl, input logic rst);
        logic acc;
        ent_t e;
        in_valid  = v;
        op_code   = opc;
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            ill_cnt = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            acc = v && (q.size() < 2);
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (acc) begin
                e = ref_decode(opc);
                q.push_back(e);
                if (e.ill) ill_cnt++;
            end
        end
        #1;
        checkOutput();
    endtask

    initial begin
        logic [20:0] a, b, c, d;
        logic [22:0] got_v, exp_v;

        vecs[0]  = '{mk(1, 4, 0, 0),     4'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 11'd0};
        vecs[1]  = '{mk(4, 7, 5, 0),     4'd0, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 11'd5};
        vecs[2]  = '{mk(10, 7, 3, 0),    4'd4, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 11'd3};
        vecs[3]  = '{mk(5, 7, 2047, 0),  4'd0, 2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 11'h7FF};
        vecs[4]  = '{mk(14, 2, 9, 3),    4'd0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b1, 11'd9};
        vecs[5]  = '{mk(1, 0, 0, 7),     4'd0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b1, 11'd0};
        vecs[6]  = '{mk(1, 2, 0, 3),     4'd0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 11'd0};
        vecs[7]  = '{mk(1, 1, 0, 1),     4'd0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 11'd0};
        vecs[8]  = '{mk(2, 0, 0, 0),     4'd0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 11'd0};
        vecs[9]  = '{mk(3, 0, 0, 0),     4'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 11'd0};
        vecs[10] = '{mk(6, 5, 0, 0),     4'd0, 2'd3, 2'd1, 2'd0, 1'b0, 1'b0, 11'd0};
        vecs[11] = '{mk(12, 0, 0, 0),    4'd6, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 11'd0};
        vecs[12] = '{mk(0, 3, 1, 2),     4'd0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 11'd1};
        vecs[13] = '{mk(7, 7, 100, 0),   4'd1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 11'd100};
        vecs[14] = '{mk(11, 6, 7, 0),    4'd5, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 11'd7};
        vecs[15] = '{mk(5, 3, 0, 0),     4'd0, 2'd2, 2'd1, 2'd2, 1'b0, 1'b0, 11'd0};

        // Reset state
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("reset_decoded_zero", 32'(dut_entry()), 32'd0);

        // Decode table streamed back to back
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, vecs[i].opc, 1'b1, 1'b0, 1'b0);
            got_v = {pc_instr, alu_instr, registers_instr, in_mux_sel, out_mux_sel, illegal, const_val};
            exp_v = {vecs[i].pc, vecs[i].alu, vecs[i].rg, vecs[i].insel, vecs[i].outsel,
                     vecs[i].ill, vecs[i].cval};
            check($sformatf("vec%0d", i), 32'(got_v), 32'(exp_v));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
        end
        check("illegal_after_table", 32'(illegal_count), 32'd2);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Output stall: head held, one op to skid, third refused
        a = mk(4, 7, 1, 0);
        b = mk(4, 7, 2, 0);
        c = mk(4, 7, 3, 0);
        d = mk(4, 7, 9, 0);
        applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, c, 1'b0, 1'b0, 1'b0);
        check("stall_head", 32'(const_val), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("drain_second", 32'(const_val), 32'd2);
        check("drain_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Flush with skid full and an op offered
        applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, d, 1'b1, 1'b1, 1'b0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("flush_dropped", 32'(out_valid), 32'd0);

        // Saturation of a two-bit counter
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, mk(13, 0, i, 0), 1'b1, 1'b0, 1'b0);
        check("sat_cnt2", 32'(illegal_count2), 32'd3);
        check("sat_cnt8", 32'(illegal_count), 32'd5);

        // Reset with skid full and four illegal ops counted
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, mk(15, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
        check("pre_reset_cnt", 32'(illegal_count), 32'd4);
        applyStimulus(1'b1, c, 1'b0, 1'b1, 1'b1);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_cnt", 32'(illegal_count), 32'd0);
        applyStimulus(1'b1, mk(4, 4, 0, 0), 1'b1, 1'b0, 1'b0);
        check("post_reset_decode", 32'({alu_instr, registers_instr, in_mux_sel}), 32'(6'b01_01_10));

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 21'($urandom()),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/op_decode_pipe.md
OP_DECODE_PIPE -- requirements
Module: op_decode_pipe

Interface
REQ-001 Parameter DATA_W, default 11, width of the immediate constant and the const_val output.
REQ-002 Parameter CNT_W, default 8, width of the illegal_count output.
REQ-003 Derived OP_W = DATA_W+10; op_code layout MSB..LSB = {op[3:0], src[2:0], imm[DATA_W-1:0], dst[2:0]}.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  op_code is valid this cycle.
REQ-007 in_ready  out  1  block can accept op_code this cycle.
REQ-008 op_code  in  OP_W  raw instruction word.
REQ-009 flush  in  1  discard all buffered entries (taken branch).
REQ-010 out_valid  out  1  decoded fields are valid.
REQ-011 out_ready  in  1  consumer accepts the decoded entry.
REQ-012 src, dst  out  3 each  src/dst fields passed through.
REQ-013 const_val  out  DATA_W  signed immediate, bit-exact copy of imm.
REQ-014 pc_instr  out  4; alu_instr  out  2; registers_instr  out  2; in_mux_sel  out  2; out_mux_sel  out  1  decoded control.
REQ-015 illegal  out  1  entry is an illegal instruction; illegal_count  out  CNT_W  saturating count of accepted illegal ops.

Function
REQ-016 Encodings: op 0 NOP,1 MOV,2 SWP,3 SAV,4 ADD,5 SUB,6 NEG,7 JMP,8 JEZ,9 JNZ,10 JGZ,11 JLZ,12 JRO,13-15 illegal; src/dst 0 ACC,1 NIL,2 LEFT,3 RIGHT,4 UP,5 DOWN,6 ANY,7 IMM.
REQ-017 Control codes: pc_instr 0 INC,1 JMP,2 JEZ,3 JNZ,4 JGZ,5 JLZ,6 JRO; alu_instr 0 PASS,1 ADD,2 SUB,3 NEG; registers_instr 0 NONE,1 WRITE_ACC,2 SWP,3 SAV; in_mux_sel 0 ACC,1 CONST,2 PORT,3 ZERO; out_mux_sel 0 internal,1 port.
REQ-018 Source select S(src): ACC->0, IMM->1, NIL->3, 2..6->2.
REQ-019 NOP: pc 0, alu 0, reg 0, in 3, out 0.
REQ-020 MOV: in S(src), alu 0, pc 0; dst ACC -> reg 1, out 0; dst NIL -> reg 0, out 0; dst 2..6 -> reg 0, out 1; dst IMM -> illegal.
REQ-021 SWP/SAV: reg 2/3, in 0, alu 0, pc 0, out 0.
REQ-022 ADD/SUB: alu 1/2, reg 1, in S(src), pc 0, out 0; NEG: alu 3, reg 1, in 0.
REQ-023 JMP..JLZ: pc 1..5, in 1, reg 0, alu 0, out 0; JRO: pc 6, in S(src), reg 0.
REQ-024 Illegal entry: control fields equal NOP, illegal=1; src/dst/const_val still passed through.
REQ-025 Transfer in when in_valid&in_ready; out when out_valid&out_ready.
REQ-026 Two-entry skid buffer (output reg + skid reg); in_ready is registered and equals "skid entry empty" (no combinational out_ready->in_ready path).
REQ-027 Latency: op accepted in cycle N is presented on outputs in cycle N+1 when the output reg is empty or draining; throughput one op per cycle with out_ready held high.
REQ-028 Output stall: with out_valid&!out_ready, outputs SHALL hold stable; one further accepted op goes to skid, then in_ready=0.
REQ-029 On output draining with skid full, skid moves to output reg next cycle, in_ready returns 1 the same edge; ordering strictly FIFO.
REQ-030 flush: next edge clears both entries (out_valid=0, in_ready=1); an op offered in the flush cycle is dropped and not counted; flush dominates simultaneous in/out handshakes.
REQ-031 illegal_count increments on acceptance (not output) of an illegal op; saturates at 2^CNT_W-1; not cleared by flush.

Reset
REQ-032 While reset=1 at an edge: out_valid=0, in_ready=1 after the edge, both entries empty, illegal_count=0, all decoded outputs 0; reset overrides flush and handshakes.
REQ-033 Reset mid-stall discards buffered entries; first op after reset SHALL decode normally.

Verification
REQ-034 Stream MOV UP,ACC; ADD 5; JGZ 3 with out_ready=1 -> one cycle later each: (in 2,reg 1), (alu 1,in 1,const 5,reg 1), (pc 4,in 1); one output per cycle.
REQ-035 SUB imm=-1 (DATA_W=11, 0x7FF) -> const_val=11'h7FF, alu 2, reg 1, in 1.
REQ-036 Hold out_ready=0, offer 3 ops -> first on output, second in skid, in_ready=0, third not accepted; release -> ops emerge in order, no loss/duplication.
REQ-037 Op 14, then MOV ACC,IMM -> both illegal=1 with NOP controls, illegal_count=2; CNT_W=2 and 5 illegal ops -> count stays 3.
REQ-038 Skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered op absent from output.
REQ-039 Assert reset with skid full and illegal_count=4 -> next cycle out_valid=0, in_ready=1, illegal_count=0.
